// File: rtl/ghffe_pkg.sv
// ghffe_pkg: definitions shared by the note scheduler slice.
//   - Note RAM word layout: [21] end marker, [20:16] fret mask, [15:0] note_time.
//   - sched_state_t: the scheduler FSM state encoding.
package ghffe_pkg;

  localparam int unsigned NOTE_W    = 22;
  localparam int unsigned END_BIT   = 21;
  localparam int unsigned FRET_HI   = 20;
  localparam int unsigned FRET_LO   = 16;
  localparam int unsigned TIME_HI   = 15;
  localparam int unsigned TIME_LO   = 0;
  localparam int unsigned NUM_FRETS = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    HOLD,
    ISSUE,
    ADVANCE,
    DONE
  } sched_state_t;

endpackage

// File: rtl/note_window_cmp.sv
// note_window_cmp: combinational timing-window test for one held note.
//   Parameters : LOOKAHEAD   - release this many ms ahead of note_time
//                MISS_WINDOW - a note is late this many ms after note_time
//   Inputs     : song_time, note_time (16-bit ms)
//   Outputs    : release_ok - song_time + LOOKAHEAD >= note_time
//                late       - song_time > note_time + MISS_WINDOW
// Both sums are formed in 17 bits so nothing wraps near the top of the
// 16-bit song range. The caller gives late priority over release_ok.
module note_window_cmp #(
  parameter logic [15:0] LOOKAHEAD   = 16'd2000,
  parameter logic [15:0] MISS_WINDOW = 16'd150
) (
  input  logic [15:0] song_time,
  input  logic [15:0] note_time,
  output logic        release_ok,
  output logic        late
);

  logic [16:0] song_ext;
  logic [16:0] due_ext;
  logic [16:0] release_point;
  logic [16:0] miss_limit;

  always_comb begin
    song_ext      = {1'b0, song_time};
    due_ext       = {1'b0, note_time};
    release_point = song_ext + {1'b0, LOOKAHEAD};
    miss_limit    = due_ext + {1'b0, MISS_WINDOW};
    release_ok    = (release_point >= due_ext);
    late          = (song_ext > miss_limit);
  end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: walks the note RAM in address order and releases each note
// to the scoring/display consumer once song_time reaches its lookahead window.
// Notes that are already past the miss window are skipped and counted.
//
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   start               - pulse: begin chart at address 0 (IDLE/DONE only)
//   song_reset          - synchronous abort back to IDLE, beats start
//   pause               - freezes the release/skip decision in HOLD
//   song_time           - current song position (ms)
//   ram_en, ram_addr    - note RAM read port
//   ram_data            - RAM word, valid one cycle after ram_en
//   note_valid/ready    - handshake to the consumer
//   note_fret/note_time - payload of the offered note
//   issued_count        - notes accepted since start (saturating)
//   skip_count          - notes skipped as late (saturating)
//   busy, done          - chart in progress / chart finished
module note_scheduler
  import ghffe_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter logic [15:0] LOOKAHEAD   = 16'd2000,
  parameter logic [15:0] MISS_WINDOW = 16'd150
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 song_reset,
  input  logic                 pause,
  input  logic [15:0]          song_time,
  output logic                 ram_en,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [NOTE_W-1:0]    ram_data,
  output logic                 note_valid,
  input  logic                 note_ready,
  output logic [NUM_FRETS-1:0] note_fret,
  output logic [15:0]          note_time,
  output logic [ADDR_W-1:0]    issued_count,
  output logic [ADDR_W-1:0]    skip_count,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  sched_state_t state;
  logic         release_ok;
  logic         late;

  // note_time doubles as the held copy of the fetched note, so the window
  // compare always looks at exactly what is (or will be) offered.
  note_window_cmp #(
    .LOOKAHEAD  (LOOKAHEAD),
    .MISS_WINDOW(MISS_WINDOW)
  ) u_window (
    .song_time (song_time),
    .note_time (note_time),
    .release_ok(release_ok),
    .late      (late)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ram_en       <= 1'b0;
      ram_addr     <= '0;
      note_valid   <= 1'b0;
      note_fret    <= '0;
      note_time    <= '0;
      issued_count <= '0;
      skip_count   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (song_reset) begin
      // Withdraws any offered note; the consumer never sees an accept.
      state        <= IDLE;
      ram_en       <= 1'b0;
      ram_addr     <= '0;
      note_valid   <= 1'b0;
      note_fret    <= '0;
      note_time    <= '0;
      issued_count <= '0;
      skip_count   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= FETCH;
            ram_en       <= 1'b1;
            ram_addr     <= '0;
            issued_count <= '0;
            skip_count   <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end

        FETCH: begin
          ram_en <= 1'b0;
          state  <= LATCH;
        end

        LATCH: begin
          note_fret <= ram_data[FRET_HI:FRET_LO];
          note_time <= ram_data[TIME_HI:TIME_LO];
          if (ram_data[END_BIT]) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= HOLD;
          end
        end

        HOLD: begin
          if (!pause) begin
            if (late) begin
              skip_count <= (skip_count == '1) ? skip_count : skip_count + ONE;
              state      <= ADVANCE;
            end else if (release_ok) begin
              note_valid <= 1'b1;
              state      <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (note_ready) begin
            note_valid   <= 1'b0;
            issued_count <= (issued_count == '1) ? issued_count : issued_count + ONE;
            state        <= ADVANCE;
          end
        end

        ADVANCE: begin
          // The last RAM slot ends the chart instead of wrapping to 0.
          if (ram_addr == '1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ram_addr <= ram_addr + ONE;
            ram_en   <= 1'b1;
            state    <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
